// File: rtl/score_display_if.sv
// score_display_if: start/value request and busy/done/overflow/leds status
// bundle between the score counter and the 7-segment driver.
interface score_display_if #(
  parameter int WIDTH      = 10,
  parameter int NUM_DIGITS = 3
);
  logic                    start;
  logic [WIDTH-1:0]        value;
  logic                    busy;
  logic                    done;
  logic                    overflow;
  logic [7*NUM_DIGITS-1:0] leds;

  modport master (output start, value, input busy, done, overflow, leds);
  modport slave  (input start, value, output busy, done, overflow, leds);
endinterface

// File: rtl/score_display.sv
// score_display: binary score -> BCD (double-dabble, one bit per cycle) ->
// NUM_DIGITS active-low 7-segment digits, saturating to all 9s on overflow.
// Optional leading-zero blanking: define SEG_LZ_BLANK_EN.
module score_display #(
  parameter int WIDTH      = 10,
  parameter int NUM_DIGITS = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  score_display_if.slave  bus
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  // Wide enough for both the input value and 10**NUM_DIGITS (<= 10**6 < 2**20).
  localparam int CMP_W = WIDTH + 24;
  localparam logic [CMP_W-1:0] LIMIT = CMP_W'(10 ** NUM_DIGITS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]   digits_q, digits_d;
  logic               overflow_q, overflow_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   adj;
  logic [7*NUM_DIGITS-1:0] leds_c;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      digits_q   <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      digits_q   <= digits_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Add-3 correction of every BCD nibble that is 5 or more.
  always_comb begin
    adj = bcd_q;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    digits_d   = digits_q;
    overflow_d = overflow_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d    = bus.value;
          bcd_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = (CMP_W'(bus.value) >= LIMIT);
          busy_d     = 1'b1;
          state_d    = CONV;
        end
      end
      CONV: begin
        // {bcd, shift} << 1 on the corrected BCD; the top BCD bit is dropped
        // (only reachable when ovf_pend already forces saturation).
        bcd_d   = {adj[BCD_W-2:0], shift_q[WIDTH-1]};
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = UPDATE;
      end
      UPDATE: begin
        if (ovf_pend_q) begin
          for (int unsigned i = 0; i < NUM_DIGITS; i++) digits_d[4*i +: 4] = 4'd9;
        end else begin
          digits_d = bcd_q;
        end
        overflow_d = ovf_pend_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Segment decode of the latched digits, most significant first so the
  // leading-zero run can be tracked.
  always_comb begin
`ifdef SEG_LZ_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    leds_c = '1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      int unsigned i;
      logic [3:0]  dig;
      logic [6:0]  code;
      i    = NUM_DIGITS - 1 - k;
      dig  = digits_q[4*i +: 4];
      code = seg7(dig);
`ifdef SEG_LZ_BLANK_EN
      if (i != 0 && lead && dig == 4'd0) code = 7'b1111111;
      if (dig != 4'd0) lead = 1'b0;
`endif
      leds_c[7*i +: 7] = code;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = overflow_q;
  assign bus.leds     = leds_c;

endmodule

// File: tb/tb_score_display.sv
// tb_score_display: randomized and directed checks of score_display in three
// configurations (10/3, 4/1, 14/5) against a divide/modulo reference model.
module tb_score_display;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  score_display_if #(.WIDTH(10), .NUM_DIGITS(3)) if0 ();
  score_display_if #(.WIDTH(4),  .NUM_DIGITS(1)) if1 ();
  score_display_if #(.WIDTH(14), .NUM_DIGITS(5)) if2 ();

  score_display #(.WIDTH(10), .NUM_DIGITS(3)) u0 (.clk(clk), .reset_n(reset_n), .bus(if0));
  score_display #(.WIDTH(4),  .NUM_DIGITS(1)) u1 (.clk(clk), .reset_n(reset_n), .bus(if1));
  score_display #(.WIDTH(14), .NUM_DIGITS(5)) u2 (.clk(clk), .reset_n(reset_n), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam int WID [3] = '{10, 4, 14};
  localparam int ND  [3] = '{3, 1, 5};

  // Reference: decimal digits by division, saturated to all 9s when too large.
  function automatic logic [41:0] exp_leds(input longint v, input int nd);
    longint lim, d, p;
    logic [41:0] r;
    logic [6:0]  code;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    d = (v >= lim) ? lim - 1 : v;
    r = '0;
    p = 1;
    for (int i = 0; i < nd; i++) begin
      code = SEG_TAB[int'((d / p) % 10)];
`ifdef SEG_LZ_BLANK_EN
      if (i > 0 && d < p) code = 7'b1111111;
`endif
      r[7*i +: 7] = code;
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic exp_ovf(input longint v, input int nd);
    longint lim;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    return v >= lim;
  endfunction

  function automatic logic [41:0] get_leds(input int w);
    case (w)
      0:       return 42'(if0.leds);
      1:       return 42'(if1.leds);
      default: return 42'(if2.leds);
    endcase
  endfunction

  function automatic logic get_done(input int w);
    case (w)
      0:       return if0.done;
      1:       return if1.done;
      default: return if2.done;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      0:       return if0.busy;
      1:       return if1.busy;
      default: return if2.busy;
    endcase
  endfunction

  function automatic logic get_ovf(input int w);
    case (w)
      0:       return if0.overflow;
      1:       return if1.overflow;
      default: return if2.overflow;
    endcase
  endfunction

  task automatic drive(input int w, input logic s, input longint v);
    case (w)
      0:       begin if0.start = s; if0.value = 10'(v); end
      1:       begin if1.start = s; if1.value = 4'(v);  end
      default: begin if2.start = s; if2.value = 14'(v); end
    endcase
  endtask

  // One conversion: start held for one edge, value scrambled afterwards;
  // returns the edge count from the start edge to done (200 = timed out).
  task automatic convert(input int w, input longint v, output int lat,
                         output logic [41:0] leds, output logic ovf);
    drive(w, 1'b1, v);
    @(posedge clk); #1;
    drive(w, 1'b0, $urandom);
    lat = 0;
    while (!get_done(w) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    leds = get_leds(w);
    ovf  = get_ovf(w);
  endtask

  task automatic test_reset();
    int lat; logic [41:0] l; logic o; logic saw_done;
    for (int w = 0; w < 3; w++) begin
      n_checks++;
      if (get_busy(w) !== 1'b0 || get_done(w) !== 1'b0 || get_ovf(w) !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_flags dut%0d: busy=%b done=%b ovf=%b, required 0 0 0",
                 w, get_busy(w), get_done(w), get_ovf(w));
      end
      n_checks++;
      if (get_leds(w) !== exp_leds(0, ND[w])) begin
        n_fail++;
        $display("FAIL reset_leds dut%0d: got %h, required %h", w, get_leds(w), exp_leds(0, ND[w]));
      end
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    convert(0, 456, lat, l, o);
    // Abort a conversion of 123 partway through.
    drive(0, 1'b1, 123);
    @(posedge clk); #1;
    drive(0, 1'b0, 0);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (get_busy(0) !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_midconv_busy_before: got %b, required 1", get_busy(0));
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (get_busy(0) !== 1'b0 || get_done(0) !== 1'b0 || get_ovf(0) !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midconv_flags: busy=%b done=%b ovf=%b, required 0 0 0",
               get_busy(0), get_done(0), get_ovf(0));
    end
    n_checks++;
    if (get_leds(0) !== exp_leds(0, 3)) begin
      n_fail++;
      $display("FAIL reset_midconv_leds: got %h, required %h", get_leds(0), exp_leds(0, 3));
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    saw_done = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (get_done(0) !== 1'b0) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0 || get_leds(0) !== exp_leds(0, 3)) begin
      n_fail++;
      $display("FAIL reset_no_done: done_seen=%b leds=%h, required 0 and %h",
               saw_done, get_leds(0), exp_leds(0, 3));
    end
  endtask

  task automatic test_basic();
    int lat; logic [41:0] l; logic o;
    convert(0, 937, lat, l, o);
    n_checks++;
    if (lat !== 11) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d edges, required 11", lat);
    end
    n_checks++;
    if (l[20:0] !== {7'b0010000, 7'b0110000, 7'b1111000} || o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_937: leds=%b ovf=%b, required 001000001100001111000 ovf=0", l[20:0], o);
    end
  endtask

  task automatic test_blanking();
    int lat; logic [41:0] l; logic o; logic [13:0] upper;
`ifdef SEG_LZ_BLANK_EN
    upper = {7'b1111111, 7'b1111111};
`else
    upper = {7'b1000000, 7'b1000000};
`endif
    convert(0, 5, lat, l, o);
    n_checks++;
    if (l[20:0] !== {upper, 7'b0010010}) begin
      n_fail++;
      $display("FAIL blank_5: got %b, required %b", l[20:0], {upper, 7'b0010010});
    end
    convert(0, 405, lat, l, o);
    n_checks++;
    if (l[20:0] !== {7'b0011001, 7'b1000000, 7'b0010010}) begin
      n_fail++;
      $display("FAIL blank_405: got %b, required 001100110000000010010", l[20:0]);
    end
  endtask

  task automatic test_overflow();
    int lat; logic [41:0] l; logic o;
    localparam logic [20:0] NINES = {7'b0010000, 7'b0010000, 7'b0010000};
    convert(0, 999, lat, l, o);
    n_checks++;
    if (l[20:0] !== NINES || o !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_999: leds=%b ovf=%b, required nines ovf=0", l[20:0], o);
    end
    convert(0, 1000, lat, l, o);
    n_checks++;
    if (l[20:0] !== NINES || o !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_1000: leds=%b ovf=%b, required nines ovf=1", l[20:0], o);
    end
    convert(0, 42, lat, l, o);
    n_checks++;
    if (l !== exp_leds(42, 3) || o !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear_42: leds=%h ovf=%b, required %h ovf=0", l, o, exp_leds(42, 3));
    end
  endtask

  // Back-to-back random conversions: each start lands on the cycle after done.
  task automatic test_back_to_back(input int w, input int count);
    int lat; logic [41:0] l; logic o; longint v;
    for (int k = 0; k < count; k++) begin
      v = longint'($urandom_range(0, (1 << WID[w]) - 1));
      convert(w, v, lat, l, o);
      n_checks++;
      if (lat !== WID[w] + 1 || l !== exp_leds(v, ND[w]) || o !== exp_ovf(v, ND[w])) begin
        n_fail++;
        $display("FAIL b2b dut%0d v=%0d: lat=%0d leds=%h ovf=%b, required lat=%0d leds=%h ovf=%b",
                 w, v, lat, l, o, WID[w] + 1, exp_leds(v, ND[w]), exp_ovf(v, ND[w]));
      end
    end
  endtask

  task automatic test_handshake();
    int lat; logic [41:0] l; logic o; logic [41:0] prev, got;
    longint a; int ndone, dlat; logic held;
    convert(0, 618, lat, l, o);
    prev = exp_leds(618, 3);
    @(posedge clk); #1;
    a = longint'($urandom_range(0, 1023));
    drive(0, 1'b1, a);
    @(posedge clk); #1;
    held = 1'b1; ndone = 0; dlat = 0; got = '0;
    for (int c = 1; c <= 30; c++) begin
      if (ndone == 0) drive(0, 1'b1, (a + 1 + longint'($urandom_range(0, 1000))) % 1024);
      else            drive(0, 1'b0, 0);
      @(posedge clk); #1;
      if (get_done(0)) begin
        ndone++;
        if (ndone == 1) begin dlat = c; got = get_leds(0); end
      end else if (ndone == 0 && get_leds(0) !== prev) begin
        held = 1'b0;
      end
    end
    n_checks++;
    if (ndone !== 1 || dlat !== 11) begin
      n_fail++;
      $display("FAIL hs_done_count: dones=%0d first_at=%0d, required 1 at 11", ndone, dlat);
    end
    n_checks++;
    if (got !== exp_leds(a, 3)) begin
      n_fail++;
      $display("FAIL hs_first_value v=%0d: got %h, required %h", a, got, exp_leds(a, 3));
    end
    n_checks++;
    if (held !== 1'b1) begin
      n_fail++;
      $display("FAIL hs_hold: display changed before done (got 0, required 1)");
    end
  endtask

  task automatic test_sweep();
    int lat; logic [41:0] l; logic o;
    convert(1, 15, lat, l, o);
    n_checks++;
    if (lat !== 5 || l[6:0] !== 7'b0010000 || o !== 1'b1) begin
      n_fail++;
      $display("FAIL sweep_w4_15: lat=%0d leds=%b ovf=%b, required 5 0010000 1", lat, l[6:0], o);
    end
    convert(2, 16383, lat, l, o);
    n_checks++;
    if (lat !== 15 || l[34:0] !== {7'b1111001, 7'b0000010, 7'b0110000, 7'b0000000, 7'b0110000}
        || o !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_w14_16383: lat=%0d leds=%b ovf=%b, required 15 digits 1,6,3,8,3 ovf 0",
               lat, l[34:0], o);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    drive(0, 1'b0, 0);
    drive(1, 1'b0, 0);
    drive(2, 1'b0, 0);
    #23;
    test_reset();
    test_basic();
    test_blanking();
    test_overflow();
    test_back_to_back(0, 20);
    test_handshake();
    test_sweep();
    test_back_to_back(1, 10);
    test_back_to_back(2, 10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
